fetch_issue_unit: RTL

- Sequencer that drives the 8-bit ALU and owns program flow.
- Fetches instructions from instruction memory and presents instruction, PC and register-file read addresses to the ALU.
- After the ALU's registered result appears, retires the instruction: PC update (sequential, jump, branch), register writeback, sticky overflow.
- Sits between instruction memory, the 4-entry register file and the ALU.

---
 rtl/fetch_issue_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit
// ----------------
// Sequencer in front of the 8-bit ALU. It fetches one instruction at a time
// from instruction memory, holds it stable for the ALU, and then retires it
// one cycle after issue. Retiring means updating the PC, writing back to the
// register file, setting the sticky overflow flag, or pulsing ls_issue so the
// memory stage can take the instruction.
//
// Port summary
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   run                   level: keep fetching / stop at the next boundary
//   imem_req/addr/rdata/valid   instruction memory fetch port
//   alu_instruction/alu_pc      instruction and its PC presented to the ALU
//   alu_out/jump/overflow       registered ALU result, valid in WAIT
//   rf_ra0/rf_ra1               register-file read addresses for ALU inputs
//   rf_we/rf_wa/rf_wd           register writeback, one-cycle pulse in WAIT
//   ls_issue                    load/store handoff pulse (opcodes 1010/1011)
//   pc, ovf_sticky, busy, retired  architectural / status outputs
//   o_dbg_state                 current FSM state (IDLE=0 FETCH=1 ISSUE=2 WAIT=3)
//
// Fetch handshake: imem_req is high for the whole of FETCH, with imem_addr
// held at pc. The instruction is taken in the first cycle in which both
// imem_req and imem_valid are high. imem_valid is ignored in every other cycle.

module fetch_issue_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_rdata,
    input  logic       imem_valid,
    output logic [7:0] alu_instruction,
    output logic [7:0] alu_pc,
    input  logic [7:0] alu_out,
    input  logic [7:0] alu_jump,
    input  logic       alu_overflow,
    output logic [1:0] rf_ra0,
    output logic [1:0] rf_ra1,
    output logic       rf_we,
    output logic [1:0] rf_wa,
    output logic [7:0] rf_wd,
    output logic       ls_issue,
    output logic [7:0] pc,
    output logic       ovf_sticky,
    output logic       busy,
    output logic       retired,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_pc;
    logic [7:0] r_instr;
    logic [7:0] r_alu_pc;
    logic       r_ovf;

    logic [3:0] w_op;
    logic [7:0] w_pc_seq;
    logic [7:0] w_br_off;
    logic       w_taken;
    logic [7:0] w_pc_next;
    logic       w_set_ovf;

    assign w_op     = r_instr[7:4];
    assign w_pc_seq = r_pc + 8'd1;
    // Branch offset is the 2-bit signed field instr[1:0] (-2..+1).
    assign w_br_off = {{6{r_instr[1]}}, r_instr[1:0]};
    // Only the exact all-ones pattern means the jump is taken.
    assign w_taken  = (alu_jump == 8'hFF);

    assign imem_addr       = r_pc;
    assign pc              = r_pc;
    assign alu_instruction = r_instr;
    assign alu_pc          = r_alu_pc;
    assign rf_ra0          = r_instr[3:2];
    assign rf_ra1          = r_instr[1:0];
    assign ovf_sticky      = r_ovf;
    assign o_dbg_state     = r_state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-PC selection. It is used only at the closing edge of WAIT.
    always_comb begin
        w_pc_next = w_pc_seq;
        case (w_op)
            4'b1000, 4'b1001: if (w_taken) w_pc_next = w_pc_seq + alu_out;
            4'b1100, 4'b1101: if (w_taken) w_pc_next = w_pc_seq + w_br_off;
            default:          w_pc_next = w_pc_seq;
        endcase
    end

    // Next state and per-state outputs, including the commit in WAIT.
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        busy         = 1'b1;
        retired      = 1'b0;
        rf_we        = 1'b0;
        rf_wa        = r_instr[3:2];
        rf_wd        = alu_out;
        ls_issue     = 1'b0;
        w_set_ovf    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                // Once a fetch has started it always completes, even if run drops.
                imem_req = 1'b1;
                if (imem_valid) w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                retired      = 1'b1;
                w_next_state = run ? S_FETCH : S_IDLE;
                if (!w_op[3] || (w_op[3:1] == 3'b111)) begin
                    rf_we = 1'b1;
                end else if (w_op == 4'b1001) begin
                    // JAL links the return address into r3.
                    rf_we = 1'b1;
                    rf_wa = 2'd3;
                    rf_wd = w_pc_seq;
                end else if (w_op[3:1] == 3'b101) begin
                    ls_issue = 1'b1;
                end
                w_set_ovf = (w_op == 4'b0001) && alu_overflow;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Instruction, issue PC, architectural PC and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_instr  <= 8'h00;
            r_alu_pc <= RESET_PC;
            r_ovf    <= 1'b0;
        end else begin
            if ((r_state == S_FETCH) && imem_valid) begin
                r_instr  <= imem_rdata;
                r_alu_pc <= r_pc;
            end
            if (r_state == S_WAIT) begin
                r_pc <= w_pc_next;
                if (w_set_ovf) r_ovf <= 1'b1;
            end
        end
    end

endmodule
